// File: rtl/nonce_sweep_scheduler.sv
// Nonce sweep sequencer: issues a nonce range to the hash core, tracks in-flight work, compares
// results against the latched target and reports found / exhausted / aborted. Option: HIT_COUNT_EN.
module nonce_sweep_scheduler #(
   parameter int MAX_INFLIGHT = 4,
   parameter int NONCE_W      = 32
) (
   input  logic               wb_clk_i,
   input  logic               wb_rst_i,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic [NONCE_W-1:0] nonce_start_i,
   input  logic [NONCE_W-1:0] nonce_end_i,
   input  logic [255:0]       target_i,
   output logic               req_valid_o,
   input  logic               req_ready_i,
   output logic [NONCE_W-1:0] req_nonce_o,
   input  logic               rsp_valid_i,
   input  logic [255:0]       rsp_hash_i,
   input  logic [NONCE_W-1:0] rsp_nonce_i,
   output logic               busy_o,
   output logic               done_o,
   output logic               found_o,
   output logic               exhausted_o,
   output logic [NONCE_W-1:0] golden_nonce_o,
   output logic [255:0]       golden_hash_o
`ifdef HIT_COUNT_EN
   ,
   output logic [15:0]        hit_count_o
`endif
);

   localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);
   localparam int LANES = 8;
   localparam logic [NONCE_W:0] CURSOR_ONE = 1;
   localparam logic [CNT_W-1:0] CNT_ONE    = 1;
   localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(MAX_INFLIGHT);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t             state_reg, state_next;
   logic [NONCE_W:0]   cursor_reg, cursor_next;
   logic [NONCE_W-1:0] end_reg, end_next;
   logic [255:0]       target_reg, target_next;
   logic [CNT_W-1:0]   inflight_reg, inflight_next;
   logic               hit_seen_reg, hit_seen_next;
   logic               abort_seen_reg, abort_seen_next;
   logic               found_reg, found_next;
   logic               exhausted_reg, exhausted_next;
   logic               done_reg, done_next;
   logic [NONCE_W-1:0] golden_nonce_reg, golden_nonce_next;
   logic [255:0]       golden_hash_reg, golden_hash_next;

   logic [LANES-1:0]   lane_lt;
   logic [LANES-1:0]   lane_eq;
   logic               hash_le;
   logic               range_left;
   logic               issue;
   logic               rsp_take;
   logic               hit;
   logic               capture;

   // Split the 256-bit compare into 32-bit lanes so the magnitude chain stays shallow.
   genvar gi;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         assign lane_lt[gi] = rsp_hash_i[gi*32 +: 32] <  target_reg[gi*32 +: 32];
         assign lane_eq[gi] = rsp_hash_i[gi*32 +: 32] == target_reg[gi*32 +: 32];
      end
   endgenerate

   always_comb begin
      hash_le = 1'b1;
      for (int i = 0; i < LANES; i++) begin
         hash_le = lane_lt[i] | (lane_eq[i] & hash_le);
      end
   end

   assign range_left  = cursor_reg <= {1'b0, end_reg};
   assign req_valid_o = (state_reg == RUN) && range_left && (inflight_reg < CNT_MAX) && !hit_seen_reg;
   assign req_nonce_o = cursor_reg[NONCE_W-1:0];
   assign issue       = req_valid_o && req_ready_i;
   assign rsp_take    = rsp_valid_i && (inflight_reg != '0);
   assign hit         = rsp_take && hash_le;
   // Hits arriving after an abort belong to a sweep that will report no result.
   assign capture     = hit && !hit_seen_reg && !abort_seen_reg;

   assign busy_o         = state_reg != IDLE;
   assign done_o         = done_reg;
   assign found_o        = found_reg;
   assign exhausted_o    = exhausted_reg;
   assign golden_nonce_o = golden_nonce_reg;
   assign golden_hash_o  = golden_hash_reg;

   always_comb begin
      state_next        = state_reg;
      cursor_next       = cursor_reg;
      end_next          = end_reg;
      target_next       = target_reg;
      inflight_next     = inflight_reg;
      hit_seen_next     = hit_seen_reg;
      abort_seen_next   = abort_seen_reg;
      found_next        = found_reg;
      exhausted_next    = exhausted_reg;
      done_next         = 1'b0;
      golden_nonce_next = golden_nonce_reg;
      golden_hash_next  = golden_hash_reg;

      case ({issue, rsp_take})
         2'b10:   inflight_next = inflight_reg + CNT_ONE;
         2'b01:   inflight_next = inflight_reg - CNT_ONE;
         default: inflight_next = inflight_reg;
      endcase

      if (issue) begin
         cursor_next = cursor_reg + CURSOR_ONE;
      end

      if (capture) begin
         hit_seen_next     = 1'b1;
         golden_nonce_next = rsp_nonce_i;
         golden_hash_next  = rsp_hash_i;
      end

      case (state_reg)
         IDLE: begin
            if (start_i) begin
               end_next          = nonce_end_i;
               target_next       = target_i;
               cursor_next       = {1'b0, nonce_start_i};
               hit_seen_next     = 1'b0;
               abort_seen_next   = 1'b0;
               found_next        = 1'b0;
               exhausted_next    = 1'b0;
               golden_nonce_next = '0;
               golden_hash_next  = '0;
               state_next        = (nonce_start_i > nonce_end_i) ? DRAIN : RUN;
            end
         end
         RUN: begin
            if (abort_i) begin
               abort_seen_next = 1'b1;
            end
            // The extra cursor bit lets an all-ones end terminate without wrapping.
            if (hit || abort_i || (cursor_next > {1'b0, end_reg})) begin
               state_next = DRAIN;
            end
         end
         DRAIN: begin
            if (inflight_next == '0) begin
               state_next     = IDLE;
               done_next      = 1'b1;
               found_next     = hit_seen_next;
               exhausted_next = !hit_seen_next && !abort_seen_reg;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state_reg        <= IDLE;
         cursor_reg       <= '0;
         end_reg          <= '0;
         target_reg       <= '0;
         inflight_reg     <= '0;
         hit_seen_reg     <= 1'b0;
         abort_seen_reg   <= 1'b0;
         found_reg        <= 1'b0;
         exhausted_reg    <= 1'b0;
         done_reg         <= 1'b0;
         golden_nonce_reg <= '0;
         golden_hash_reg  <= '0;
      end else begin
         state_reg        <= state_next;
         cursor_reg       <= cursor_next;
         end_reg          <= end_next;
         target_reg       <= target_next;
         inflight_reg     <= inflight_next;
         hit_seen_reg     <= hit_seen_next;
         abort_seen_reg   <= abort_seen_next;
         found_reg        <= found_next;
         exhausted_reg    <= exhausted_next;
         done_reg         <= done_next;
         golden_nonce_reg <= golden_nonce_next;
         golden_hash_reg  <= golden_hash_next;
      end
   end

`ifdef HIT_COUNT_EN
   logic [15:0] hit_count_reg, hit_count_next;

   always_comb begin
      hit_count_next = hit_count_reg;
      if (hit && (hit_count_reg != 16'hFFFF)) begin
         hit_count_next = hit_count_reg + 16'd1;
      end
      if ((state_reg == IDLE) && start_i) begin
         hit_count_next = '0;
      end
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         hit_count_reg <= '0;
      end else begin
         hit_count_reg <= hit_count_next;
      end
   end

   assign hit_count_o = hit_count_reg;
`endif

endmodule

// File: tb/tb_nonce_sweep_scheduler.sv
// Bench for nonce_sweep_scheduler: table of sweeps against an in-order hash core model, with
// scoreboards for issued nonces and sweep outcomes, plus hand sequences for stall/abort/reset.
module tb_nonce_sweep_scheduler;

   localparam int MAXI = 4;

   typedef struct {
      logic [31:0]  ns;
      logic [31:0]  ne;
      logic [255:0] target;
      bit           hit_all;
      bit           has_hit;
      logic [31:0]  hit_nonce;
      int           lat;
      bit           exp_found;
      bit           exp_exh;
      logic [31:0]  exp_golden;
      int           exp_count;
   } vec_t;

   typedef struct {
      logic [31:0] nonce;
      int          due;
   } pend_t;

   typedef struct {
      bit           found;
      bit           exh;
      logic [31:0]  gn;
      logic [255:0] gh;
   } out_t;

   logic         clk = 1'b0;
   logic         wb_rst_i;
   logic         start_i;
   logic         abort_i;
   logic [31:0]  nonce_start_i;
   logic [31:0]  nonce_end_i;
   logic [255:0] target_i;
   logic         req_valid_o;
   logic         req_ready_i;
   logic [31:0]  req_nonce_o;
   logic         rsp_valid_i;
   logic [255:0] rsp_hash_i;
   logic [31:0]  rsp_nonce_i;
   logic         busy_o;
   logic         done_o;
   logic         found_o;
   logic         exhausted_o;
   logic [31:0]  golden_nonce_o;
   logic [255:0] golden_hash_o;
`ifdef HIT_COUNT_EN
   logic [15:0]  hit_count_o;
`endif

   always #5 clk = ~clk;

   nonce_sweep_scheduler #(.MAX_INFLIGHT(MAXI), .NONCE_W(32)) dut (
      .wb_clk_i       (clk),
      .wb_rst_i       (wb_rst_i),
      .start_i        (start_i),
      .abort_i        (abort_i),
      .nonce_start_i  (nonce_start_i),
      .nonce_end_i    (nonce_end_i),
      .target_i       (target_i),
      .req_valid_o    (req_valid_o),
      .req_ready_i    (req_ready_i),
      .req_nonce_o    (req_nonce_o),
      .rsp_valid_i    (rsp_valid_i),
      .rsp_hash_i     (rsp_hash_i),
      .rsp_nonce_i    (rsp_nonce_i),
      .busy_o         (busy_o),
      .done_o         (done_o),
      .found_o        (found_o),
      .exhausted_o    (exhausted_o),
      .golden_nonce_o (golden_nonce_o),
      .golden_hash_o  (golden_hash_o)
`ifdef HIT_COUNT_EN
      ,
      .hit_count_o    (hit_count_o)
`endif
   );

   int          n_tests;
   int          n_fail;
   int          cyc;
   int          issued;
   int          done_cnt;
   int          done_cyc;
   int          last_rsp_cyc;
   int          rsp_seen;
   int          hits_sent;
   int          latency;
   int          rsp_budget;
   bit          ready_en;
   vec_t        cur;
   vec_t        vecs[7];
   logic [31:0] exp_q[$];
   pend_t       pending[$];
   out_t        outc_q[$];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   function automatic bit is_hit(input logic [31:0] n);
      return cur.hit_all || (cur.has_hit && (n == cur.hit_nonce));
   endfunction

   // Hits return exactly the target (equality boundary); misses return target+1.
   function automatic logic [255:0] hash_of(input logic [31:0] n);
      return is_hit(n) ? cur.target : cur.target + 256'd1;
   endfunction

   function automatic vec_t mk(input logic [31:0] ns, input logic [31:0] ne, input logic [255:0] t,
                               input bit hit_all, input bit has_hit, input logic [31:0] hn,
                               input int lat, input bit ef, input bit ee, input logic [31:0] eg,
                               input int ec);
      vec_t v;
      v.ns = ns; v.ne = ne; v.target = t; v.hit_all = hit_all; v.has_hit = has_hit;
      v.hit_nonce = hn; v.lat = lat; v.exp_found = ef; v.exp_exh = ee; v.exp_golden = eg;
      v.exp_count = ec;
      return v;
   endfunction

   // One clock: drive core responses and ready, score any handshake, advance past the edge.
   task automatic step();
      int    pend_before = pending.size();
      pend_t p;
      if (done_o) begin
         done_cnt++;
         done_cyc = cyc;
      end
      rsp_valid_i = 1'b0;
      rsp_hash_i  = '0;
      rsp_nonce_i = '0;
      if (rsp_budget != 0 && pending.size() > 0 && pending[0].due <= cyc) begin
         p = pending.pop_front();
         rsp_valid_i = 1'b1;
         rsp_nonce_i = p.nonce;
         rsp_hash_i  = hash_of(p.nonce);
         if (is_hit(p.nonce)) hits_sent++;
         last_rsp_cyc = cyc;
         rsp_seen++;
         if (rsp_budget > 0) rsp_budget--;
      end
      req_ready_i = ready_en;
      if (req_valid_o && ready_en) begin
         chk("inflight_below_max", pend_before < MAXI, 1'b1);
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL req_nonce: got %0h, expected no further request", req_nonce_o);
         end else begin
            chk("req_nonce", req_nonce_o, exp_q.pop_front());
         end
         p.nonce = req_nonce_o;
         p.due   = cyc + latency;
         pending.push_back(p);
         issued++;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic begin_sweep(input vec_t v);
      out_t o;
      cur = v;
      exp_q.delete();
      pending.delete();
      issued = 0; done_cnt = 0; rsp_seen = 0; hits_sent = 0;
      latency = v.lat; rsp_budget = -1; ready_en = 1'b1;
      if (v.ns <= v.ne) begin
         for (longint n = longint'(v.ns); n <= longint'(v.ne); n++) exp_q.push_back(32'(n));
      end
      o.found = v.exp_found;
      o.exh   = v.exp_exh;
      o.gn    = v.exp_found ? v.exp_golden : 32'h0;
      o.gh    = v.exp_found ? v.target : 256'h0;
      outc_q.push_back(o);
      nonce_start_i = v.ns;
      nonce_end_i   = v.ne;
      target_i      = v.target;
      start_i       = 1'b1;
      step();
      start_i = 1'b0;
      chk("busy_after_start", busy_o, 1'b1);
      chk("valid_1cyc_after_start", req_valid_o, v.ns <= v.ne);
   endtask

   task automatic finish_sweep(input vec_t v, input string tag);
      out_t o;
      for (int c = 0; c < 2000 && done_cnt == 0; c++) step();
      if (done_cnt == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s done_timeout: got no done_o, expected one within 2000 cycles", tag);
      end
      if (outc_q.size() > 0) begin
         o = outc_q.pop_front();
         chk($sformatf("%s found", tag), found_o, o.found);
         chk($sformatf("%s exhausted", tag), exhausted_o, o.exh);
         chk($sformatf("%s golden_nonce", tag), golden_nonce_o, o.gn);
         chk($sformatf("%s golden_hash", tag), golden_hash_o, o.gh);
      end
      chk($sformatf("%s done_is_pulse", tag), done_o, 1'b0);
      chk($sformatf("%s idle_after_done", tag), busy_o, 1'b0);
      chk($sformatf("%s drained", tag), pending.size(), 0);
      if (v.exp_count >= 0) chk($sformatf("%s issued", tag), issued, v.exp_count);
      if (rsp_seen > 0) chk($sformatf("%s done_latency", tag), done_cyc, last_rsp_cyc + 1);
`ifdef HIT_COUNT_EN
      chk($sformatf("%s hit_count", tag), hit_count_o, hits_sent);
`endif
      step();
      step();
      chk($sformatf("%s single_done", tag), done_cnt, 1);
      chk($sformatf("%s flags_held", tag), {found_o, exhausted_o}, {o.found, o.exh});
   endtask

   task automatic chk_zero(input string tag);
      chk($sformatf("%s req_valid", tag), req_valid_o, 1'b0);
      chk($sformatf("%s req_nonce", tag), req_nonce_o, 32'h0);
      chk($sformatf("%s busy", tag), busy_o, 1'b0);
      chk($sformatf("%s done", tag), done_o, 1'b0);
      chk($sformatf("%s found", tag), found_o, 1'b0);
      chk($sformatf("%s exhausted", tag), exhausted_o, 1'b0);
      chk($sformatf("%s golden_nonce", tag), golden_nonce_o, 32'h0);
      chk($sformatf("%s golden_hash", tag), golden_hash_o, 256'h0);
`ifdef HIT_COUNT_EN
      chk($sformatf("%s hit_count", tag), hit_count_o, 16'h0);
`endif
   endtask

   initial begin
      vec_t v;
      n_tests = 0; n_fail = 0; cyc = 0;
      wb_rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0;
      nonce_start_i = '0; nonce_end_i = '0; target_i = '0;
      req_ready_i = 1'b0; rsp_valid_i = 1'b0; rsp_hash_i = '0; rsp_nonce_i = '0;
      ready_en = 1'b1; rsp_budget = -1; latency = 1;
      cur = mk(0, 0, 256'h0, 0, 0, 0, 1, 0, 0, 0, -1);

      vecs[0] = mk(32'h10, 32'h13, {256{1'b1}}, 1, 0, 0, 3, 1, 0, 32'h10, -1);
      vecs[1] = mk(32'h0, 32'h7, 256'h0, 0, 0, 0, 2, 0, 1, 0, 8);
      vecs[2] = mk(32'hFFFF_FFFE, 32'hFFFF_FFFF, 256'h0, 0, 0, 0, 1, 0, 1, 0, 2);
      vecs[3] = mk(32'h5, 32'h4, 256'h0, 0, 0, 0, 1, 0, 1, 0, 0);
      vecs[4] = mk(32'h20, 32'h2F, 256'h1000, 0, 1, 32'h25, 2, 1, 0, 32'h25, -1);
      vecs[5] = mk(32'h0, 32'h5, 256'hABCD, 0, 0, 0, 5, 0, 1, 0, 6);
      vecs[6] = mk(32'h0, 32'h2, {256{1'b1}}, 1, 0, 0, 5, 1, 0, 32'h0, 3);

      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      wb_rst_i = 1'b0;

      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      chk("abort_in_idle busy", busy_o, 1'b0);
      chk("abort_in_idle done", done_o, 1'b0);

      for (int i = 0; i < 7; i++) begin
         begin_sweep(vecs[i]);
         finish_sweep(vecs[i], $sformatf("vec%0d", i));
      end

      // Inflight limit, ready stall stability, start ignored while busy.
      v = mk(32'h0, 32'h9, 256'h0, 0, 0, 0, 1, 0, 1, 0, 10);
      begin_sweep(v);
      rsp_budget = 0;
      for (int c = 0; c < 20 && issued < MAXI; c++) step();
      for (int c = 0; c < 3; c++) begin
         chk("limit valid_low", req_valid_o, 1'b0);
         step();
      end
      rsp_budget = 1;
      step();
      chk("limit released valid", req_valid_o, 1'b1);
      chk("limit released nonce", req_nonce_o, 32'h4);
      ready_en = 1'b0;
      nonce_start_i = 32'h500;
      nonce_end_i   = 32'h600;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      for (int c = 0; c < 3; c++) begin
         chk("stall valid", req_valid_o, 1'b1);
         chk("stall nonce", req_nonce_o, 32'h4);
         step();
      end
      ready_en = 1'b1;
      rsp_budget = -1;
      finish_sweep(v, "limit");

      // Abort with three requests outstanding.
      v = mk(32'h0, 32'd99, 256'h0, 0, 0, 0, 1, 0, 0, 0, 3);
      begin_sweep(v);
      rsp_budget = 0;
      for (int c = 0; c < 20 && issued < 3; c++) step();
      ready_en = 1'b0;
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      chk("abort valid_drops", req_valid_o, 1'b0);
      chk("abort still_busy", busy_o, 1'b1);
      rsp_budget = -1;
      finish_sweep(v, "abort");

      // Reset mid-sweep followed by stale response strobes that would hit a zero target.
      v = mk(32'h0, 32'd99, 256'h0, 0, 0, 0, 2, 0, 1, 0, -1);
      begin_sweep(v);
      repeat (5) step();
      wb_rst_i = 1'b1;
      req_ready_i = 1'b1;
      rsp_valid_i = 1'b0;
      @(posedge clk);
      #1;
      wb_rst_i = 1'b0;
      req_ready_i = 1'b0;
      for (int k = 0; k < 3; k++) begin
         rsp_valid_i = 1'b1;
         rsp_nonce_i = 32'(k);
         rsp_hash_i  = 256'h0;
         @(posedge clk);
         #1;
         chk("stale_rsp busy", busy_o, 1'b0);
      end
      rsp_valid_i = 1'b0;
      chk_zero("after_reset");
      pending.delete();
      outc_q.delete();

      begin_sweep(vecs[1]);
      finish_sweep(vecs[1], "post_reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
